// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key tracker.
// Holds the frame FSM state encoding, the E0/F0 prefix bytes and the event record.
// The odd-parity helper is shared so the frame checker stays readable.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam int         EVT_W   = 10;

    // One decoded key event as stored in the event FIFO.
    typedef struct packed {
        logic       ext;
        logic [0:0] brk;
        logic [7:0] code;
    } ps2_evt_t;

    // PS/2 uses odd parity: data bits plus the parity bit must hold an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
        return ^{dat, par};
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Event FIFO: push/full write port, valid/ready read port, DEPTH entries of WIDTH bits.
// Latency: a pushed entry is visible on rd_vld/rd_dat the cycle after the push edge.
// Backpressure: push is accepted when not full, or when full and a pop happens in the same cycle.
module ps2_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    output logic             full,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the index bits match.
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_vld  = (wptr != rptr);
    assign rd_dat  = mem[rptr[AW-1:0]];
    assign do_pop  = rd_vld & rd_rdy;
    assign do_push = push & (~full | do_pop);

    // Storage array; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= push_dat;
        end
    end

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 receiver that decodes E0/F0 prefixes, tracks held keys from a table and queues all events.
// Latency: byte strobe 2 clk after a falling PS/2 edge, key_down/FIFO write 1 clk after the strobe.
// Backpressure: events wait in the FIFO for evt_ready; a full FIFO drops the event and pulses evt_ovf.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int                      NUM_KEYS    = 5,
    parameter logic [NUM_KEYS*9-1:0]   KEY_CODES   = {9'h05A, 9'h04B, 9'h042, 9'h01B, 9'h01C},
    parameter int                      FIFO_DEPTH  = 8,
    parameter int                      TIMEOUT_CYC = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] key_down,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [7:0]          evt_code,
    output logic                evt_ext,
    output logic                evt_break,
    output logic                frame_err,
    output logic                evt_ovf
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    // Synchroniser stages: index 0 is the first flop, index 1 the older sample.
    logic [1:0]      clk_sync;
    logic [1:0]      dat_sync;
    logic            ps2_fall;
    logic            ps2_bit;

    ps2_state_t      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic [TO_W-1:0] to_cnt;
    logic            byte_stb;
    logic [7:0]      byte_dat;

    logic            ext_flag;
    logic            brk_flag;

    logic            evt_push;
    ps2_evt_t        push_evt;
    logic            fifo_full;
    logic [EVT_W-1:0] head_bits;
    ps2_evt_t        head_evt;

    assign ps2_fall = clk_sync[1] & ~clk_sync[0];
    assign ps2_bit  = dat_sync[1];

    // Bring the raw PS/2 lines into the clk domain; idle-high reset value avoids a false edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // Frame FSM: start, 8 data bits LSB-first, parity, stop; inter-edge timeout aborts a stalled frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            byte_stb  <= 1'b0;
            byte_dat  <= '0;
            frame_err <= 1'b0;
        end else begin
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;

            if (state == IDLE || ps2_fall) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (state != IDLE && !ps2_fall && to_cnt == TO_LAST) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end else if (ps2_fall) begin
                case (state)
                    IDLE: begin
                        // A high level here is not a start bit; stay put.
                        if (!ps2_bit) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {ps2_bit, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= ps2_bit;
                        state   <= STOP;
                    end
                    STOP: begin
                        if (ps2_bit && odd_parity_ok(shreg, par_bit)) begin
                            byte_stb <= 1'b1;
                            byte_dat <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Any byte other than a prefix becomes an event tagged with the pending prefix flags.
    always_comb begin
        evt_push      = byte_stb && (byte_dat != PS2_EXT) && (byte_dat != PS2_BRK);
        push_evt      = '0;
        push_evt.ext  = ext_flag;
        push_evt.brk  = brk_flag;
        push_evt.code = byte_dat;
    end

    // Prefix tracking and key table update; a framing error abandons any pending prefix.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            key_down <= '0;
        end else if (frame_err) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (byte_stb) begin
            if (byte_dat == PS2_EXT) begin
                ext_flag <= 1'b1;
            end else if (byte_dat == PS2_BRK) begin
                brk_flag <= 1'b1;
            end else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (KEY_CODES[i*9 +: 9] == {ext_flag, byte_dat}) begin
                        key_down[i] <= ~brk_flag;
                    end
                end
            end
        end
    end

    // Flag an event lost to a full FIFO; a same-cycle pop frees a slot so nothing is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_ovf <= 1'b0;
        end else begin
            evt_ovf <= evt_push & fifo_full & ~(evt_valid & evt_ready);
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (evt_push),
        .push_dat (push_evt),
        .full     (fifo_full),
        .rd_vld   (evt_valid),
        .rd_rdy   (evt_ready),
        .rd_dat   (head_bits)
    );

    assign head_evt  = head_bits;
    assign evt_code  = head_evt.code;
    assign evt_ext   = head_evt.ext;
    assign evt_break = head_evt.brk;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: drives PS/2 frames bit by bit and compares against a key/event model.
// The model applies the prefix and key-table rules per received byte and keeps the expected event list.
// Frame errors, timeouts, overflow and reset are exercised alongside randomized byte streams.
module tb_ps2_key_tracker;

    localparam int          NK    = 6;
    localparam logic [53:0] TBL   = {9'h174, 9'h05A, 9'h04B, 9'h042, 9'h01B, 9'h01C};
    localparam int          DEPTH = 8;
    localparam int          TO    = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ps2_clk = 1'b1;
    logic          ps2_data = 1'b1;
    logic [NK-1:0] key_down;
    logic          evt_valid;
    logic          evt_ready = 1'b1;
    logic [7:0]    evt_code;
    logic          evt_ext;
    logic          evt_break;
    logic          frame_err;
    logic          evt_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor bookkeeping (written only by the monitor process).
    logic [9:0] got[$];
    int         err_seen = 0;
    int         ovf_seen = 0;

    // Model state (written only by the stimulus process).
    logic [9:0]    exp_q[$];
    int            got_idx = 0;
    logic [NK-1:0] m_keys = '0;
    logic          m_ext = 1'b0;
    logic          m_brk = 1'b0;
    bit            hold_mode = 1'b0;
    int            m_ovf = 0;
    int            half = 4;
    bit            rand_ready = 1'b0;

    ps2_key_tracker #(
        .NUM_KEYS    (NK),
        .KEY_CODES   (TBL),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_down  (key_down),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_break (evt_break),
        .frame_err (frame_err),
        .evt_ovf   (evt_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_seen++;
        if (evt_ovf === 1'b1) ovf_seen++;
        if (evt_valid === 1'b1 && evt_ready === 1'b1) got.push_back({evt_ext, evt_break, evt_code});
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) evt_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        cyc(half);
        ps2_clk = 1'b0;
        cyc(half);
        ps2_clk = 1'b1;
    endtask

    // Model: one correctly received byte.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (hold_mode && exp_q.size() >= DEPTH) m_ovf++;
            else exp_q.push_back({m_ext, m_brk, b});
            for (int i = 0; i < NK; i++)
                if (TBL[i*9 +: 9] == {m_ext, b}) m_keys[i] = ~m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_err();
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        cyc(12);
        if (bad_par || bad_stop) model_err();
        else model_byte(b);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc(3);
        @(negedge clk);
        n_cmp++;
        if ({key_down, evt_valid, frame_err, evt_ovf} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got kd=%b v=%b fe=%b ovf=%b want all 0", key_down, evt_valid, frame_err, evt_ovf);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        cyc(4);
    endtask

    task automatic test_make();
        logic [10:0] f;
        evt_ready = 1'b0;
        f = {1'b1, ~^8'h1C, 8'h1C, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        cyc(half);
        ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (key_down[0] !== 1'b0 || evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL make_early: got kd0=%b valid=%b want 0/0", key_down[0], evt_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (key_down[0] !== 1'b1 || evt_valid !== 1'b1 || {evt_ext, evt_break, evt_code} !== 10'h01C) begin
            n_bad++;
            $display("FAIL make_latency: got kd0=%b valid=%b evt=%h want 1/1/01c", key_down[0], evt_valid, {evt_ext, evt_break, evt_code});
        end
        @(posedge clk); #1;
        cyc(half);
        ps2_clk = 1'b1;
        model_byte(8'h1C);
        evt_ready = 1'b1;
        cyc(8);
        n_cmp++;
        if (got.size() - got_idx != exp_q.size()) begin
            n_bad++;
            $display("FAIL make_evt_count: got %0d want %0d", got.size() - got_idx, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && got_idx + i < got.size(); i++) begin
            n_cmp++;
            if (got[got_idx + i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL make_evt[%0d]: got %h want %h", i, got[got_idx + i], exp_q[i]);
            end
        end
        got_idx = got.size();
        exp_q.delete();
    endtask

    task automatic test_break();
        send_frame(8'hF0);
        send_frame(8'h1C);
        n_cmp++;
        if (key_down !== m_keys || key_down[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL break_keys: got %b want %b", key_down, m_keys);
        end
        n_cmp++;
        if (got.size() - got_idx != exp_q.size()) begin
            n_bad++;
            $display("FAIL break_evt_count: got %0d want %0d", got.size() - got_idx, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && got_idx + i < got.size(); i++) begin
            n_cmp++;
            if (got[got_idx + i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL break_evt[%0d]: got %h want %h", i, got[got_idx + i], exp_q[i]);
            end
        end
        got_idx = got.size();
        exp_q.delete();
    endtask

    task automatic test_ext();
        send_frame(8'hE0);
        send_frame(8'h74);
        n_cmp++;
        if (key_down !== m_keys) begin
            n_bad++;
            $display("FAIL ext_make_keys: got %b want %b", key_down, m_keys);
        end
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h74);
        n_cmp++;
        if (key_down !== m_keys) begin
            n_bad++;
            $display("FAIL ext_break_keys: got %b want %b", key_down, m_keys);
        end
        n_cmp++;
        if (got.size() - got_idx != exp_q.size()) begin
            n_bad++;
            $display("FAIL ext_evt_count: got %0d want %0d", got.size() - got_idx, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && got_idx + i < got.size(); i++) begin
            n_cmp++;
            if (got[got_idx + i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL ext_evt[%0d]: got %h want %h", i, got[got_idx + i], exp_q[i]);
            end
        end
        got_idx = got.size();
        exp_q.delete();
    endtask

    task automatic test_errors();
        int e0;
        e0 = err_seen;
        send_frame(8'hE0);
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'h74);
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'hF0);
        send_frame(8'h1B);
        n_cmp++;
        if (err_seen - e0 != 2) begin
            n_bad++;
            $display("FAIL err_pulses: got %0d want 2", err_seen - e0);
        end
        n_cmp++;
        if (key_down !== m_keys) begin
            n_bad++;
            $display("FAIL err_keys: got %b want %b", key_down, m_keys);
        end
        n_cmp++;
        if (got.size() - got_idx != exp_q.size()) begin
            n_bad++;
            $display("FAIL err_evt_count: got %0d want %0d", got.size() - got_idx, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && got_idx + i < got.size(); i++) begin
            n_cmp++;
            if (got[got_idx + i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL err_evt[%0d]: got %h want %h", i, got[got_idx + i], exp_q[i]);
            end
        end
        got_idx = got.size();
        exp_q.delete();
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_seen;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        cyc(TO + 10);
        model_err();
        n_cmp++;
        if (err_seen - e0 != 1) begin
            n_bad++;
            $display("FAIL timeout_pulse: got %0d want 1", err_seen - e0);
        end
        send_frame(8'h1B);
        n_cmp++;
        if (key_down !== m_keys || key_down[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_recover_keys: got %b want %b", key_down, m_keys);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [8];
        logic [7:0] b;
        bit         bad;
        pool = '{8'h1C, 8'h1B, 8'h42, 8'h4B, 8'h5A, 8'h74, 8'hE0, 8'hF0};
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            half = $urandom_range(3, 8);
            b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
            bad = ($urandom_range(0, 9) == 0);
            send_frame(b, bad, 1'b0);
            n_cmp++;
            if (key_down !== m_keys) begin
                n_bad++;
                $display("FAIL rand_keys[%0d]: byte %h got %b want %b", n, b, key_down, m_keys);
            end
        end
        rand_ready = 1'b0;
        half = 4;
        evt_ready = 1'b1;
        cyc(20);
        n_cmp++;
        if (got.size() - got_idx != exp_q.size()) begin
            n_bad++;
            $display("FAIL rand_evt_count: got %0d want %0d", got.size() - got_idx, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && got_idx + i < got.size(); i++) begin
            n_cmp++;
            if (got[got_idx + i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL rand_evt[%0d]: got %h want %h", i, got[got_idx + i], exp_q[i]);
            end
        end
        got_idx = got.size();
        exp_q.delete();
    endtask

    task automatic test_overflow();
        int o0;
        send_frame(8'hF0);
        send_frame(8'h1C);
        cyc(5);
        got_idx = got.size();
        exp_q.delete();
        o0 = ovf_seen;
        m_ovf = 0;
        evt_ready = 1'b0;
        hold_mode = 1'b1;
        for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i));
        send_frame(8'h1C);
        n_cmp++;
        if (ovf_seen - o0 != m_ovf || m_ovf != 1) begin
            n_bad++;
            $display("FAIL ovf_pulses: got %0d want %0d", ovf_seen - o0, m_ovf);
        end
        n_cmp++;
        if (key_down !== m_keys || evt_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_keys: got kd=%b valid=%b want kd=%b valid=1", key_down, evt_valid, m_keys);
        end
        hold_mode = 1'b0;
        evt_ready = 1'b1;
        cyc(20);
        n_cmp++;
        if (got.size() - got_idx != exp_q.size()) begin
            n_bad++;
            $display("FAIL ovf_evt_count: got %0d want %0d", got.size() - got_idx, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && got_idx + i < got.size(); i++) begin
            n_cmp++;
            if (got[got_idx + i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL ovf_evt[%0d]: got %h want %h", i, got[got_idx + i], exp_q[i]);
            end
        end
        got_idx = got.size();
        exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        rst = 1'b0;
        cyc(3);
        n_cmp++;
        if (key_down !== '0 || evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got kd=%b valid=%b want 0/0", key_down, evt_valid);
        end
        rst = 1'b1;
        cyc(3);
        m_keys = '0;
        model_err();
        send_frame(8'h1B);
        n_cmp++;
        if (key_down !== m_keys) begin
            n_bad++;
            $display("FAIL midreset_keys: got %b want %b", key_down, m_keys);
        end
        n_cmp++;
        if (got.size() - got_idx != exp_q.size()) begin
            n_bad++;
            $display("FAIL midreset_evt_count: got %0d want %0d", got.size() - got_idx, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && got_idx + i < got.size(); i++) begin
            n_cmp++;
            if (got[got_idx + i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL midreset_evt[%0d]: got %h want %h", i, got[got_idx + i], exp_q[i]);
            end
        end
        got_idx = got.size();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_ext();
        test_errors();
        test_timeout();
        test_random();
        test_overflow();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
